// File: rtl/product_drain_pkg.sv
// Shared definitions for the product drain block and the upstream multiplier:
// FSM state encoding and default geometry.
package product_drain_pkg;

    localparam int DEF_LOGDEPTH = 6;
    localparam int DEF_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } drain_state_t;

endpackage

// File: rtl/drain_accum.sv
// Running sum / max / count of the current burst. The *_next outputs show the
// values including the beat presented this cycle, so a burst can close on it.
module drain_accum
    import product_drain_pkg::*;
#(
    parameter int LOGDEPTH = DEF_LOGDEPTH,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          data,
    output logic [WIDTH+LOGDEPTH-1:0] sum_next,
    output logic [WIDTH-1:0]          max_next,
    output logic [LOGDEPTH:0]         count_next
);

    localparam logic [LOGDEPTH:0] COUNT_ONE = {{LOGDEPTH{1'b0}}, 1'b1};

    logic [WIDTH+LOGDEPTH-1:0] sum_reg;
    logic [WIDTH-1:0]          max_reg;
    logic [LOGDEPTH:0]         count_reg;

    always_comb begin
        sum_next   = sum_reg;
        max_next   = max_reg;
        count_next = count_reg;
        if (enable) begin
            sum_next   = sum_reg + {{LOGDEPTH{1'b0}}, data};
            // Strictly greater: an equal beat leaves the max untouched.
            max_next   = (data > max_reg) ? data : max_reg;
            count_next = count_reg + COUNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg   <= '0;
            max_reg   <= '0;
            count_reg <= '0;
        end else if (clear) begin
            sum_reg   <= '0;
            max_reg   <= '0;
            count_reg <= '0;
        end else if (enable) begin
            sum_reg   <= sum_next;
            max_reg   <= max_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/product_drain.sv
// Drains one block of products from the multiplier as a burst of beats and
// presents its sum, max and beat count to a consumer.
module product_drain
    import product_drain_pkg::*;
#(
    parameter int LOGDEPTH = DEF_LOGDEPTH,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      EN_drain,
    output logic                      RDY_drain,
    output logic                      EN_blockRead,
    input  logic                      VALID_memVal,
    input  logic [WIDTH-1:0]          memVal_data,
    output logic                      RDY_result,
    input  logic                      EN_result,
    output logic [WIDTH+LOGDEPTH-1:0] result_sum,
    output logic [WIDTH-1:0]          result_max,
    output logic [LOGDEPTH:0]         result_count
);

    localparam logic [LOGDEPTH:0] COUNT_FULL = {1'b1, {LOGDEPTH{1'b0}}};

    drain_state_t state_reg;
    drain_state_t state_next;

    logic                      acc_clear;
    logic                      acc_enable;
    logic                      latch_result;
    logic [WIDTH+LOGDEPTH-1:0] sum_next;
    logic [WIDTH-1:0]          max_next;
    logic [LOGDEPTH:0]         count_next;

    drain_accum #(
        .LOGDEPTH (LOGDEPTH),
        .WIDTH    (WIDTH)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .enable     (acc_enable),
        .data       (memVal_data),
        .sum_next   (sum_next),
        .max_next   (max_next),
        .count_next (count_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (EN_drain) state_next = REQ;
            end
            REQ: begin
                if (VALID_memVal) begin
                    state_next = (count_next == COUNT_FULL) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                // Burst closes on the first gap or on the beat that fills the block.
                if (!VALID_memVal || (count_next == COUNT_FULL)) state_next = DONE;
            end
            DONE: begin
                if (EN_result) state_next = EN_drain ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        RDY_drain    = (state_reg == IDLE);
        EN_blockRead = (state_reg == REQ);
        RDY_result   = (state_reg == DONE);
        acc_clear    = ((state_reg == IDLE) && EN_drain) ||
                       ((state_reg == DONE) && EN_result && EN_drain);
        acc_enable   = VALID_memVal && ((state_reg == REQ) || (state_reg == COLLECT));
        latch_result = ((state_reg == REQ) || (state_reg == COLLECT)) && (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_sum   <= '0;
            result_max   <= '0;
            result_count <= '0;
        end else if (latch_result) begin
            result_sum   <= sum_next;
            result_max   <= max_next;
            result_count <= count_next;
        end
    end

endmodule

// File: tb/tb_product_drain.sv
// Self-checking bench for product_drain: table vectors, directed corner cases
// and random bursts checked against a transaction-level burst model.
module tb_product_drain;
    import product_drain_pkg::*;

    localparam int LD  = DEF_LOGDEPTH;
    localparam int W   = DEF_WIDTH;
    localparam int CAP = 1 << LD;

    logic           clk;
    logic           rst;
    logic           EN_drain;
    logic           RDY_drain;
    logic           EN_blockRead;
    logic           VALID_memVal;
    logic [W-1:0]   memVal_data;
    logic           RDY_result;
    logic           EN_result;
    logic [W+LD-1:0] result_sum;
    logic [W-1:0]   result_max;
    logic [LD:0]    result_count;

    product_drain #(.LOGDEPTH(LD), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .EN_drain     (EN_drain),
        .RDY_drain    (RDY_drain),
        .EN_blockRead (EN_blockRead),
        .VALID_memVal (VALID_memVal),
        .memVal_data  (memVal_data),
        .RDY_result   (RDY_result),
        .EN_result    (EN_result),
        .result_sum   (result_sum),
        .result_max   (result_max),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Beat pattern of the burst under test, one entry per cycle after REQ.
    bit          v_arr [128];
    logic [31:0] d_arr [128];
    int          n_cyc;

    typedef struct {
        logic [0:7][31:0] d;
        logic [0:7]       v;
        logic [63:0]      s;
        logic [63:0]      m;
        logic [63:0]      c;
    } vec_t;
    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [0:7][31:0] d, input logic [0:7] v,
                           input logic [63:0] s, input logic [63:0] m, input logic [63:0] c);
        vec_t t;
        t.d = d; t.v = v; t.s = s; t.m = m; t.c = c;
        tbl.push_back(t);
    endtask

    // Burst = leading run of valid beats, cut at the first gap or at CAP beats.
    task automatic model_burst(output logic [63:0] es, output logic [63:0] em,
                               output logic [63:0] ec, output int eend);
        es = 0; em = 0; ec = 0; eend = -1;
        for (int i = 0; i < n_cyc; i++) begin
            if (!v_arr[i]) begin
                eend = i;
                break;
            end
            es += 64'(d_arr[i]);
            if (64'(d_arr[i]) > em) em = 64'(d_arr[i]);
            ec++;
            if (ec == 64'(CAP)) begin
                eend = i;
                break;
            end
        end
    endtask

    task automatic consume(input string tag);
        EN_result = 1'b1;
        step();
        EN_result = 1'b0;
        chk({tag, ".rdy_result_drop"}, 64'(RDY_result), 64'd0);
        chk({tag, ".rdy_drain_back"},  64'(RDY_drain),  64'd1);
    endtask

    task automatic run_burst(input bit start, input int pre_wait, input bit noise, input string tag);
        logic [63:0] es, em, ec;
        int eend;
        model_burst(es, em, ec, eend);
        if (eend < 0) begin
            total++; bad++;
            $display("FAIL %s.pattern: burst never ends within %0d cycles", tag, n_cyc);
            eend = n_cyc;
        end
        if (start) begin
            chk({tag, ".rdy_drain_idle"}, 64'(RDY_drain), 64'd1);
            EN_drain = 1'b1;
            step();
            EN_drain = 1'b0;
            chk({tag, ".blockread_rise"}, 64'(EN_blockRead), 64'd1);
            chk({tag, ".rdy_drain_busy"}, 64'(RDY_drain), 64'd0);
        end
        for (int w = 0; w < pre_wait; w++) begin
            EN_drain     = noise;
            EN_result    = noise;
            VALID_memVal = 1'b0;
            memVal_data  = $urandom;
            step();
        end
        EN_drain  = 1'b0;
        EN_result = 1'b0;
        if (pre_wait > 0) begin
            chk({tag, ".blockread_wait"}, 64'(EN_blockRead), 64'd1);
            chk({tag, ".rdy_result_wait"}, 64'(RDY_result), 64'd0);
        end
        for (int i = 0; i < n_cyc; i++) begin
            VALID_memVal = v_arr[i];
            memVal_data  = d_arr[i];
            if (noise && i <= eend) begin
                EN_drain  = 1'b1;
                EN_result = ($urandom_range(0, 1) == 1);
            end else begin
                EN_drain  = 1'b0;
                EN_result = 1'b0;
            end
            step();
            if (i == 0) chk({tag, ".blockread_drop"}, 64'(EN_blockRead), 64'd0);
            chk({tag, ".rdy_result_timing"}, 64'(RDY_result), 64'(i >= eend));
        end
        VALID_memVal = 1'b0;
        EN_drain     = 1'b0;
        EN_result    = 1'b0;
        chk({tag, ".sum"},   64'(result_sum),   es);
        chk({tag, ".max"},   64'(result_max),   em);
        chk({tag, ".count"}, 64'(result_count), ec);
        $display("burst %s: count=%0d sum=%0h max=%0h", tag, result_count, result_sum, result_max);
    endtask

    task automatic clear_pattern();
        for (int i = 0; i < 128; i++) begin
            v_arr[i] = 1'b0;
            d_arr[i] = 32'd0;
        end
    endtask

    initial begin
        rst = 1'b0; EN_drain = 1'b0; EN_result = 1'b0;
        VALID_memVal = 1'b0; memVal_data = '0;
        #2;
        chk("reset.rdy_drain",  64'(RDY_drain),    64'd1);
        chk("reset.blockread",  64'(EN_blockRead), 64'd0);
        chk("reset.rdy_result", 64'(RDY_result),   64'd0);
        chk("reset.sum",        64'(result_sum),   64'd0);
        chk("reset.max",        64'(result_max),   64'd0);
        chk("reset.count",      64'(result_count), 64'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Stray VALID / EN_result in IDLE must do nothing.
        VALID_memVal = 1'b1; memVal_data = 32'd55; EN_result = 1'b1;
        step();
        VALID_memVal = 1'b0; EN_result = 1'b0;
        chk("idle.rdy_drain",  64'(RDY_drain),    64'd1);
        chk("idle.blockread",  64'(EN_blockRead), 64'd0);
        chk("idle.rdy_result", 64'(RDY_result),   64'd0);

        add_vec({32'd5, 32'd9, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0},
                8'b1101_0000, 64'd14, 64'd9, 64'd2);
        add_vec({32'd0, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                8'b1000_0000, 64'd0, 64'd0, 64'd1);
        add_vec({32'd3, 32'd3, 32'd3, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0},
                8'b1110_0000, 64'd9, 64'd3, 64'd3);
        add_vec({32'd7, 32'd2, 32'd8, 32'd8, 32'd1, 32'd50, 32'd0, 32'd0},
                8'b1111_1000, 64'd26, 64'd8, 64'd5);
        add_vec({32'h8000_0000, 32'h7FFF_FFFF, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                8'b1100_0000, 64'hFFFF_FFFF, 64'h8000_0000, 64'd2);
        add_vec({32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd99},
                8'b1111_1110, 64'd280, 64'd70, 64'd7);

        for (int t = 0; t < tbl.size(); t++) begin
            clear_pattern();
            for (int j = 0; j < 8; j++) begin
                v_arr[j] = tbl[t].v[j];
                d_arr[j] = tbl[t].d[j];
            end
            n_cyc = 8;
            run_burst(1'b1, t % 3, (t % 2) == 1, "tbl");
            chk("tbl.sum_const",   64'(result_sum),   tbl[t].s);
            chk("tbl.max_const",   64'(result_max),   tbl[t].m);
            chk("tbl.count_const", 64'(result_count), tbl[t].c);
            consume("tbl");
        end

        // 63 beats 1..63, then a gap.
        clear_pattern();
        for (int k = 1; k <= 63; k++) begin
            v_arr[k-1] = 1'b1;
            d_arr[k-1] = 32'(k);
        end
        d_arr[63] = 32'd1000;
        n_cyc = 64;
        run_burst(1'b1, 2, 1'b0, "ramp63");
        chk("ramp63.sum_const",   64'(result_sum),   64'd2016);
        chk("ramp63.max_const",   64'(result_max),   64'd63);
        chk("ramp63.count_const", 64'(result_count), 64'd63);
        consume("ramp63");

        // VALID held for 70 cycles of all-ones: burst caps at 64 beats.
        clear_pattern();
        for (int i = 0; i < 70; i++) begin
            v_arr[i] = 1'b1;
            d_arr[i] = 32'hFFFF_FFFF;
        end
        n_cyc = 72;
        run_burst(1'b1, 0, 1'b0, "full64");
        chk("full64.sum_const",   64'(result_sum),   64'h3F_FFFF_FFC0);
        chk("full64.max_const",   64'(result_max),   64'hFFFF_FFFF);
        chk("full64.count_const", 64'(result_count), 64'd64);
        consume("full64");

        // Simultaneous EN_result + EN_drain in DONE chains straight into a new burst.
        clear_pattern();
        v_arr[0] = 1'b1; d_arr[0] = 32'd500;
        v_arr[1] = 1'b1; d_arr[1] = 32'd300;
        n_cyc = 3;
        run_burst(1'b1, 0, 1'b0, "chainA");
        EN_result = 1'b1; EN_drain = 1'b1;
        step();
        EN_result = 1'b0; EN_drain = 1'b0;
        chk("chain.rdy_result_drop", 64'(RDY_result),   64'd0);
        chk("chain.blockread_rise",  64'(EN_blockRead), 64'd1);
        chk("chain.rdy_drain",       64'(RDY_drain),    64'd0);
        clear_pattern();
        v_arr[0] = 1'b1; d_arr[0] = 32'd2;
        v_arr[1] = 1'b1; d_arr[1] = 32'd4;
        n_cyc = 3;
        run_burst(1'b0, 1, 1'b0, "chainB");
        chk("chainB.sum_const",   64'(result_sum),   64'd6);
        chk("chainB.max_const",   64'(result_max),   64'd4);
        chk("chainB.count_const", 64'(result_count), 64'd2);
        consume("chainB");

        // Reset mid-burst after 10 beats abandons the burst.
        EN_drain = 1'b1;
        step();
        EN_drain = 1'b0;
        for (int i = 0; i < 10; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = 32'($urandom_range(1, 100));
            step();
        end
        rst = 1'b0;
        #1;
        chk("midrst.rdy_drain",  64'(RDY_drain),    64'd1);
        chk("midrst.blockread",  64'(EN_blockRead), 64'd0);
        chk("midrst.rdy_result", 64'(RDY_result),   64'd0);
        chk("midrst.sum",        64'(result_sum),   64'd0);
        chk("midrst.max",        64'(result_max),   64'd0);
        chk("midrst.count",      64'(result_count), 64'd0);
        step(); step();
        rst = 1'b1;
        step();
        chk("postrst.rdy_drain", 64'(RDY_drain),    64'd1);
        chk("postrst.blockread", 64'(EN_blockRead), 64'd0);
        VALID_memVal = 1'b0;
        clear_pattern();
        v_arr[0] = 1'b1; d_arr[0] = 32'd2;
        v_arr[1] = 1'b1; d_arr[1] = 32'd2;
        n_cyc = 3;
        run_burst(1'b1, 0, 1'b0, "postrst");
        chk("postrst.sum_const",   64'(result_sum),   64'd4);
        chk("postrst.count_const", 64'(result_count), 64'd2);
        consume("postrst");

        // Random bursts against the model.
        for (int r = 0; r < 20; r++) begin
            int len;
            clear_pattern();
            len   = $urandom_range(1, 80);
            n_cyc = len + 1 + $urandom_range(0, 3);
            for (int i = 0; i < n_cyc; i++) begin
                if (i < len)       v_arr[i] = 1'b1;
                else if (i == len) v_arr[i] = 1'b0;
                else               v_arr[i] = ($urandom_range(0, 1) == 1);
                d_arr[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            end
            run_burst(1'b1, $urandom_range(0, 2), (r % 2) == 1, "rand");
            consume("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_drain.md
PRODUCT_DRAIN -- requirements
Module: product_drain

Interface
REQ-001 Parameter LOGDEPTH, default 6: log2 of the product block depth; maximum beats per burst is 2^LOGDEPTH = 64.
REQ-002 Parameter WIDTH, default 32: product word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 clears all state immediately.
REQ-005 EN_drain  input  1  request to drain one product block; accepted only while RDY_drain=1.
REQ-006 RDY_drain  output  1  block is idle and can accept EN_drain.
REQ-007 EN_blockRead  output  1  read request to the upstream multiplier; held high until the first valid beat arrives.
REQ-008 VALID_memVal  input  1  upstream beat valid.
REQ-009 memVal_data  input  WIDTH  upstream product word, unsigned.
REQ-010 RDY_result  output  1  result registers hold a completed burst.
REQ-011 EN_result  input  1  consumer takes the result; effective only while RDY_result=1.
REQ-012 result_sum  output  WIDTH+LOGDEPTH  unsigned sum of all beats in the burst.
REQ-013 result_max  output  WIDTH  largest beat value in the burst.
REQ-014 result_count  output  LOGDEPTH+1  number of beats in the burst, 1..2^LOGDEPTH.

Function
REQ-015 The state machine SHALL have the states IDLE, REQ, COLLECT and DONE.
REQ-016 In IDLE, RDY_drain SHALL be 1; EN_drain=1 SHALL clear the accumulators and move to REQ at the next edge.
REQ-017 In REQ, EN_blockRead SHALL be 1 (registered, first high one cycle after EN_drain is accepted); the block SHALL wait indefinitely for VALID_memVal=1.
REQ-018 A VALID_memVal=1 in REQ SHALL be accumulated as beat 1, and the state SHALL move to COLLECT; EN_blockRead SHALL go 0 at that same edge.
REQ-019 In COLLECT, each cycle with VALID_memVal=1 SHALL add memVal_data to sum (zero-extended, no overflow possible), update max, and increment count.
REQ-020 A burst SHALL end on the first cycle in COLLECT with VALID_memVal=0; that cycle adds nothing.
REQ-021 A burst SHALL also end on the edge that accepts beat 2^LOGDEPTH; any VALID beats after that SHALL be ignored.
REQ-022 At burst end, result_sum, result_max and result_count SHALL be latched, and RDY_result SHALL be 1 from the next cycle, in DONE.
REQ-023 The result outputs SHALL stay stable while RDY_result=1.
REQ-024 In DONE, EN_result=1 SHALL return the block to IDLE; if EN_drain=1 in the same cycle, the block SHALL go directly to REQ with cleared accumulators.
REQ-025 EN_drain SHALL be ignored outside IDLE, except as in REQ-024.
REQ-026 EN_result SHALL be ignored outside DONE.
REQ-027 VALID_memVal in IDLE or DONE SHALL be ignored.
REQ-028 The max update SHALL use an unsigned compare; equal values leave max unchanged.
REQ-029 The block SHALL NOT drive data toward the multiplier other than EN_blockRead.

Reset
REQ-030 While rst=0, the state SHALL be IDLE, RDY_drain=1, EN_blockRead=0, RDY_result=0, and result_sum, result_max and result_count SHALL all be 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no partial result; after release the block SHALL wait for a new EN_drain.
REQ-032 Reset deassertion SHALL take effect at the first rising clk edge after rst returns to 1.

Structure
REQ-033 The state enum (drain_state_t, 2 bits) and the default LOGDEPTH/WIDTH constants SHALL live in a shared package, also imported by the multiplier; state enums SHALL NOT be declared at file scope.
REQ-034 The sum/max/count datapath SHALL be one sub-module, drain_accum, with clear and enable inputs; the FSM stays in product_drain.
REQ-035 The design SHALL have no combinational path from VALID_memVal or memVal_data to any output.

Verification
REQ-036 EN_drain pulse, then 63 consecutive beats of value k (k=1..63) -> EN_blockRead 1 until first beat; result_sum=2016, result_max=63, result_count=63; RDY_result one cycle after VALID falls.
REQ-037 64 beats of 0xFFFFFFFF with VALID held high for 70 cycles -> result_count=64, result_sum=0x3F_FFFFFFC0, result_max=0xFFFFFFFF; beats 65-70 ignored.
REQ-038 Beats 5, 9, gap, 7 -> burst ends at the gap; result_count=2, result_sum=14, result_max=9; the later 7 is ignored in DONE.
REQ-039 rst=0 after 10 beats, released, new drain of beats 2, 2 -> all outputs 0 during reset; result_sum=4, result_count=2.
REQ-040 In DONE, EN_result and EN_drain high together -> RDY_result drops, EN_blockRead high next cycle, and the new burst result is independent of the old one.
REQ-041 EN_drain held in REQ/COLLECT and EN_result pulsed outside DONE -> no state or output change.
